// File: rtl/alu_sched_pkg.sv
// Shared definitions for the round-robin add/subtract scheduler:
// FSM state encoding, operation mode encoding and the default width.
package alu_sched_pkg;

    // Default operand/result width
    localparam int ALU_SCHED_WIDTH = 4;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Operation mode carried with each request
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/add_sub_unit.sv
// Purely combinational ripple-carry adder/subtractor.
// SUB is formed as a + ~b + 1: operand B is inverted by the mode bit and the
// mode bit is also injected as the carry into bit 0. The carry into the MSB
// is exported so the parent can derive signed overflow when it needs it.
module add_sub_unit #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             m,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_b_eff;

    // Ripple the carry through one full adder per bit
    always_comb begin
        w_b_eff    = b ^ {WIDTH{m}};
        w_carry    = '0;
        w_carry[0] = m;
        sum        = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]       = a[i] ^ w_b_eff[i] ^ w_carry[i];
            w_carry[i+1] = (a[i] & w_b_eff[i]) | (w_carry[i] & (a[i] ^ w_b_eff[i]));
        end
    end

    assign cout    = w_carry[WIDTH];
    assign msb_cin = w_carry[WIDTH-1];

endmodule

// File: rtl/alu_rr_scheduler.sv
// Two requesters share one add/subtract datapath under round-robin arbitration.
// Each operation walks IDLE (accept) -> EXEC (compute, register) -> RESP (hold
// result until the consumer takes it).
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// Requesters hold valid and operands stable until ready; the scheduler only
// raises reqN_ready in IDLE for the granted requester. The response side holds
// rsp_valid and every rsp_* field stable until rsp_ready.
//
// Optional feature macro: ALU_SCHED_OVF_EN adds the rsp_ovf port and the
// signed-overflow register. Without it there is no rsp_ovf port.
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int WIDTH = ALU_SCHED_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_m,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_m,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
`ifdef ALU_SCHED_OVF_EN
    output logic             rsp_ovf,
`endif
    output logic [1:0]       dbg_state
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rr_ptr;
    logic             r_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_m;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_any_valid;
    logic             w_grant_id;
    logic             w_accept;
    logic             w_rsp_fire;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_msb_cin;

    // Arbiter: a lone requester wins; on contention the round-robin pointer decides
    always_comb begin
        w_any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant_id = r_rr_ptr;
        end else begin
            w_grant_id = req1_valid;
        end
    end

    // Next-state and handshake outputs of the scheduler FSM
    always_comb begin
        w_state_nxt = r_state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        w_accept    = 1'b0;
        w_rsp_fire  = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_valid) begin
                    req0_ready  = ~w_grant_id;
                    req1_ready  = w_grant_id;
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_rsp_fire  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the granted requester's operands and identity on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a  <= '0;
            r_b  <= '0;
            r_m  <= MODE_ADD;
            r_id <= 1'b0;
        end else if (w_accept) begin
            r_id <= w_grant_id;
            if (w_grant_id) begin
                r_a <= req1_a;
                r_b <= req1_b;
                r_m <= req1_m;
            end else begin
                r_a <= req0_a;
                r_b <= req0_b;
                r_m <= req0_m;
            end
        end
    end

    // Shared datapath, fed only from the captured operands
    add_sub_unit #(
        .WIDTH (WIDTH)
    ) u_add_sub (
        .a       (r_a),
        .b       (r_b),
        .m       (r_m == MODE_SUB),
        .sum     (w_sum),
        .cout    (w_cout),
        .msb_cin (w_msb_cin)
    );

    // Register the result at the end of the EXEC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_sum  <= w_sum;
            r_cout <= w_cout;
        end
    end

    // After a delivered response, the other requester gets priority next time
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_rsp_fire) begin
            r_rr_ptr <= ~r_id;
        end
    end

`ifdef ALU_SCHED_OVF_EN
    logic r_ovf;

    // Signed overflow: carry into the MSB differs from carry out of the MSB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_EXEC) begin
            r_ovf <= w_msb_cin ^ w_cout;
        end
    end

    assign rsp_ovf = r_ovf;
`else
    logic w_unused_msb_cin;
    assign w_unused_msb_cin = w_msb_cin;
`endif

    assign rsp_id    = r_id;
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with an expected-result queue.
module tb_alu_rr_scheduler;
    import alu_sched_pkg::*;

    localparam int W = 4;
    localparam int BUDGET = 20;

    logic         clk;
    logic         rst;
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_m;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_m;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
`ifdef ALU_SCHED_OVF_EN
    logic         rsp_ovf;
`endif
    logic [1:0]   dbg_state;

    // Expected entry layout: {ovf, id, cout, sum}
    logic [W+2:0] exp_q[$];
    int checks;
    int failures;

    alu_rr_scheduler #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_m     (req0_m),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_m     (req1_m),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
`ifdef ALU_SCHED_OVF_EN
        .rsp_ovf    (rsp_ovf),
`endif
        .dbg_state  (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: plain integer arithmetic, unsigned compare for borrow
    function automatic logic [W+2:0] model(input logic id, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic m);
        logic [W:0]   full;
        logic [W-1:0] s;
        logic         c;
        logic         v;
        if (m == MODE_ADD) begin
            full = {1'b0, a} + {1'b0, b};
            s = full[W-1:0];
            c = full[W];
            v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            s = a - b;
            c = (a >= b);
            v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end
        return {v, id, c, s};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare it with the presented response
    task automatic check_rsp();
        logic [W+2:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL rsp_unexpected observed=%0h expected=none", rsp_sum);
        end else begin
            e = exp_q.pop_front();
            check("rsp_sum", 32'(rsp_sum), 32'(e[W-1:0]));
            check("rsp_cout", 32'(rsp_cout), 32'(e[W]));
            check("rsp_id", 32'(rsp_id), 32'(e[W+1]));
`ifdef ALU_SCHED_OVF_EN
            check("rsp_ovf", 32'(rsp_ovf), 32'(e[W+2]));
`endif
        end
    endtask

    // Bounded wait (from a sampling point) for the given ready to rise
    task automatic wait_grant(input logic id);
        int n;
        n = 0;
        while (!(id ? req1_ready : req0_ready) && n < BUDGET) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(id ? "grant1" : "grant0", 32'(id ? req1_ready : req0_ready), 32'd1);
    endtask

    // Record the accepted operation, let the edge take it, then drop valid
    task automatic grant_and_push(input logic id, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic m);
        exp_q.push_back(model(id, a, b, m));
        @(posedge clk);
        #1;
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic drive_req(input logic id, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic m);
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_m = m;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_m = m;
        end
        #1;
        wait_grant(id);
        grant_and_push(id, a, b, m);
    endtask

    // Called just after the accept edge; waits for the response and takes it
    task automatic collect_rsp(input bit chk_lat);
        int n;
        n = 0;
        @(negedge clk);
        check("exec_ready0", 32'(req0_ready), 32'd0);
        check("exec_ready1", 32'(req1_ready), 32'd0);
        while (!rsp_valid && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("rsp_valid_seen", 32'(rsp_valid), 32'd1);
        if (chk_lat) check("latency", 32'(n), 32'd1);
        check_rsp();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        logic [W+2:0] e;
        logic win;
        checks = 0;
        failures = 0;
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_m = MODE_ADD;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_m = MODE_ADD;
        rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        check("rst_rsp_cout", 32'(rsp_cout), 32'd0);
`ifdef ALU_SCHED_OVF_EN
        check("rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
`endif
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rst = 1'b0;

        // Directed arithmetic cases, with latency checked on the first
        drive_req(1'b0, 4'b1010, 4'b0101, MODE_ADD);
        collect_rsp(1'b1);
        drive_req(1'b1, 4'b1010, 4'b0011, MODE_SUB);
        collect_rsp(1'b1);
        drive_req(1'b0, 4'b0011, 4'b1010, MODE_SUB);
        collect_rsp(1'b0);

        // Back-pressure: response held, pending req1 must wait for IDLE
        rsp_ready = 1'b0;
        drive_req(1'b0, 4'b0110, 4'b0011, MODE_ADD);
        req1_valid = 1'b1; req1_a = 4'b1100; req1_b = 4'b0100; req1_m = MODE_SUB;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("hold_rsp_seen", 32'(rsp_valid), 32'd1);
        check_rsp();
        e = model(1'b0, 4'b0110, 4'b0011, MODE_ADD);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_sum", 32'(rsp_sum), 32'(e[W-1:0]));
            check("hold_cout", 32'(rsp_cout), 32'(e[W]));
            check("hold_id", 32'(rsp_id), 32'(e[W+1]));
            check("hold_ready0", 32'(req0_ready), 32'd0);
            check("hold_ready1", 32'(req1_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check("hs_cycle_ready1", 32'(req1_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("post_hs_state", 32'(dbg_state), 32'(ST_IDLE));
        check("post_hs_ready1", 32'(req1_ready), 32'd1);
        grant_and_push(1'b1, 4'b1100, 4'b0100, MODE_SUB);
        collect_rsp(1'b0);

        // Wrap-around boundary; also leaves the round-robin pointer at 1
        drive_req(1'b0, 4'b1111, 4'b0001, MODE_ADD);
        collect_rsp(1'b0);

        // Reset during EXEC discards the operation
        drive_req(1'b1, 4'b0101, 4'b0010, MODE_ADD);
        check("pre_rst_state", 32'(dbg_state), 32'(ST_EXEC));
        rst = 1'b1;
        #1;
        void'(exp_q.pop_back());
        check("midrst_valid", 32'(rsp_valid), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("midrst_sum", 32'(rsp_sum), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("postrst_valid", 32'(rsp_valid), 32'd0);
        end

        // Both valid from reset: req0 first, then strict alternation
        req0_valid = 1'b1; req0_a = W'($urandom_range(0, 15)); req0_b = W'($urandom_range(0, 15));
        req0_m = 1'($urandom_range(0, 1));
        req1_valid = 1'b1; req1_a = W'($urandom_range(0, 15)); req1_b = W'($urandom_range(0, 15));
        req1_m = 1'($urandom_range(0, 1));
        for (int k = 0; k < 6; k++) begin
            n = 0;
            #1;
            while (!(req0_ready || req1_ready) && n < BUDGET) begin
                @(negedge clk);
                #1;
                n++;
            end
            check("alt_grant_seen", 32'(req0_ready | req1_ready), 32'd1);
            check("alt_single_ready", 32'(req0_ready & req1_ready), 32'd0);
            check("alt_order", 32'(req1_ready), 32'(k % 2));
            win = req1_ready;
            if (win) exp_q.push_back(model(1'b1, req1_a, req1_b, req1_m));
            else     exp_q.push_back(model(1'b0, req0_a, req0_b, req0_m));
            @(posedge clk);
            #1;
            if (win) begin
                req1_a = W'($urandom_range(0, 15)); req1_b = W'($urandom_range(0, 15));
                req1_m = 1'($urandom_range(0, 1));
            end else begin
                req0_a = W'($urandom_range(0, 15)); req0_b = W'($urandom_range(0, 15));
                req0_m = 1'($urandom_range(0, 1));
            end
            collect_rsp(1'b0);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Signed overflow case (sum and carry checked in every build)
        drive_req(1'b0, 4'b0111, 4'b0001, MODE_ADD);
        collect_rsp(1'b0);

        // Random single-requester operations
        for (int k = 0; k < 8; k++) begin
            drive_req(1'($urandom_range(0, 1)), W'($urandom_range(0, 15)),
                      W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            collect_rsp(1'b1);
        end

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
